// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo_hs: pointer/count width and parameter legality.
// The optional error flags are enabled by defining SYNC_FIFO_HS_ERR_EN.
package sync_fifo_pkg;

    // Pointers and count both need one bit beyond the index to represent FIFO_DEPTH.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2_ge2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(
        input int data_width,
        input int fifo_depth,
        input int af_level,
        input int ae_level
    );
        return (data_width >= 1)
            && is_pow2_ge2(fifo_depth)
            && (af_level >= 1) && (af_level <= fifo_depth)
            && (ae_level >= 0) && (ae_level <= fifo_depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage for sync_fifo_hs: one synchronous write port, one asynchronous read port.
// The array is deliberately never reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          wr_en,
    input  logic [$clog2(FIFO_DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [$clog2(FIFO_DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_hs.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Define SYNC_FIFO_HS_ERR_EN to add sticky ovf_err/udf_err outputs.
module sync_fifo_hs
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                              clock,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [ptr_width(FIFO_DEPTH)-1:0]  count,
    output logic                              almost_full,
    output logic                              almost_empty
`ifdef SYNC_FIFO_HS_ERR_EN
    ,
    output logic                              ovf_err,
    output logic                              udf_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR  = PW'(AE_LEVEL);

    if (!params_legal(DATA_WIDTH, FIFO_DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("sync_fifo_hs: illegal DATA_WIDTH/FIFO_DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;

    // Handshake: a beat transfers on a rising edge iff valid && ready on that side;
    // ready/valid here depend only on registered pointers, never on the peer's input.
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    // Pointers wrap naturally modulo 2*FIFO_DEPTH; the extra bit tells full from empty.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_THR);
    assign almost_empty = (count_q <= AE_THR);

`ifdef SYNC_FIFO_HS_ERR_EN
    // Sticky protocol-violation flags; observational only, the data path ignores them.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (flush) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                ovf_err <= 1'b1;
            end
            if (out_ready && !out_valid) begin
                udf_err <= 1'b1;
            end
        end
    end
`endif

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Self-checking bench for sync_fifo_hs (64 x 8, AF=6, AE=2).
// Covers the SYNC_FIFO_HS_ERR_EN flags when that macro is defined.
module tb_sync_fifo_hs;

    logic        clock = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  count;
    logic        almost_full;
    logic        almost_empty;
`ifdef SYNC_FIFO_HS_ERR_EN
    logic        ovf_err;
    logic        udf_err;
`endif

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [63:0] din;
        logic [3:0]  ecount;
        logic        eir;
        logic        eov;
        logic        eaf;
        logic        eae;
    } vec_t;

    vec_t vecs[18];

    sync_fifo_hs #(
        .DATA_WIDTH (64),
        .FIFO_DEPTH (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef SYNC_FIFO_HS_ERR_EN
        ,
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [63:0] d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = d;
    endtask

    // Sample handshakes mid-cycle, update the scoreboard, then advance one clock.
    task automatic step();
        logic [63:0] exp;
        @(negedge clock);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL sb_pop: got read of %0h expected no read (queue empty)", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_data", out_data, exp);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [3:0] c, input logic ir,
                                input logic ov, input logic af, input logic ae);
        check({tag, ".count"}, 64'(count), 64'(c));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        check({tag, ".almost_full"}, 64'(almost_full), 64'(af));
        check({tag, ".almost_empty"}, 64'(almost_empty), 64'(ae));
    endtask

    initial begin
        // Fill to full, one rejected write, drain, one read at empty.
        vecs[0]  = '{1'b1, 1'b0, 64'h10, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 64'h11, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 64'h12, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 64'h13, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 64'h14, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 64'h15, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 64'h16, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 64'h17, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 64'h18, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 64'h00, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 64'h00, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 64'h00, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 64'h00, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 64'h00, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 64'h00, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 64'h00, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 64'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 64'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Clock/reset
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (3) @(posedge clock);
        #1;
        check_status("reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;

        // Table: first write lands on the first edge after reset release.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, 1'b0, vecs[i].din);
            step();
            check_status($sformatf("vec%0d", i), vecs[i].ecount, vecs[i].eir,
                         vecs[i].eov, vecs[i].eaf, vecs[i].eae);
        end
        check("table_drained", 64'(exp_q.size()), 64'd0);
`ifdef SYNC_FIFO_HS_ERR_EN
        check("ovf_err_set", 64'(ovf_err), 64'd1);
        check("udf_err_set", 64'(udf_err), 64'd1);
`endif
        drive(1'b0, 1'b0, 1'b1, 64'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
`ifdef SYNC_FIFO_HS_ERR_EN
        check("ovf_err_flushed", 64'(ovf_err), 64'd0);
        check("udf_err_flushed", 64'(udf_err), 64'd0);
`endif

        // Write into empty: visible exactly one cycle later, not in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 64'hAA);
        @(negedge clock);
        check("no_bypass.out_valid", 64'(out_valid), 64'd0);
        if (in_ready) exp_q.push_back(in_data);
        @(posedge clock);
        #1;
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check("latency.out_valid", 64'(out_valid), 64'd1);
        check("latency.out_data", out_data, 64'hAA);
        drive(1'b0, 1'b1, 1'b0, 64'h0);
        step();
        check("aa_drained.count", 64'(count), 64'd0);

        // Steady-state streaming at count 4 across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, {$urandom, $urandom});
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, {$urandom, $urandom});
            step();
            check($sformatf("stream%0d.count", i), 64'(count), 64'd4);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 64'h0);
            step();
        end
        check("stream_drained.out_valid", 64'(out_valid), 64'd0);

        // Random traffic; occupancy must track the scoreboard depth.
        for (int i = 0; i < 150; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom});
            step();
            check("rand.count", 64'(count), 64'(exp_q.size()));
        end
        while (exp_q.size() != 0 && total < 100000) begin
            drive(1'b0, 1'b1, 1'b0, 64'h0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        step();
        check("rand_drained.count", 64'(count), 64'd0);

        // Flush at count 5 with a concurrent write.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'h100 + 64'(i));
            step();
        end
        check("pre_flush.count", 64'(count), 64'd5);
        drive(1'b1, 1'b0, 1'b1, 64'hDEAD);
        step();
        check("flush.count", 64'(count), 64'd0);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        step();
        check("flush_discard.count", 64'(count), 64'd0);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'h200 + 64'(i));
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 64'h203);
        #1;
        rst = 1'b0;
        #1;
        check_status("async_rst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.delete();
        @(posedge clock);
        #1;
        check("rst_held.count", 64'(count), 64'd0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'h55);
        step();
        check("post_rst_write.count", 64'(count), 64'd1);
        check("post_rst_write.out_data", out_data, 64'h55);
        drive(1'b0, 1'b1, 1'b0, 64'h0);
        step();
        check("post_rst_drain.count", 64'(count), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
